// File: rtl/fnn_pkg.sv
// Shared types and constants for the layer-to-layer neuron datapath.
// Holds the serializer state encoding and index sizing helper.
package fnn_pkg;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_STREAM,
        SER_GAP
    } ser_state_t;

    // Idle cycles inserted after every burst; neurons use the valid fall as end-of-vector.
    localparam int SER_GAP_CYCLES = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Gathers one layer's parallel neuron outputs into a vector and replays it as a
// single contiguous valid burst followed by one idle cycle for the next layer.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int numNeuron = 10,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron*dataWidth-1:0] neuron_out,
    input  logic [numNeuron-1:0]           neuron_outvalid,
    output logic [dataWidth-1:0]           myinput,
    output logic                           myinputValid,
    output logic                           busy,
    output logic                           overflow
);

    localparam int IDX_W = idx_width(numNeuron);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeuron - 1);

    ser_state_t           state;
    ser_state_t           state_next;
    logic [IDX_W-1:0]     idx;
    logic [numNeuron-1:0] got;
    logic [numNeuron-1:0] got_now;
    logic [dataWidth-1:0] cap        [numNeuron];
    logic [dataWidth-1:0] cap_next   [numNeuron];
    logic [dataWidth-1:0] stream_buf [numNeuron];
    logic                 pending;
    logic                 complete;
    logic                 can_handoff;
    logic                 handoff;
    logic                 overflow_q;

    // A full got mask that survived an edge means the vector is waiting for the stream side.
    always_comb begin
        pending     = &got;
        got_now     = pending ? got : (got | neuron_outvalid);
        for (int i = 0; i < numNeuron; i++) begin
            cap_next[i] = cap[i];
            if (!pending && neuron_outvalid[i]) begin
                cap_next[i] = neuron_out[i*dataWidth +: dataWidth];
            end
        end
        complete    = &got_now;
        can_handoff = (state == SER_IDLE) || (state == SER_GAP);
        handoff     = complete && can_handoff;
    end

    always_comb begin
        state_next = state;
        case (state)
            SER_IDLE:   if (handoff) state_next = SER_STREAM;
            SER_STREAM: if (idx == LAST_IDX) state_next = SER_GAP;
            SER_GAP:    state_next = handoff ? SER_STREAM : SER_IDLE;
            default:    state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SER_IDLE;
            idx        <= '0;
            got        <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            got   <= handoff ? '0 : got_now;
            if (pending && (|neuron_outvalid)) begin
                overflow_q <= 1'b1;
            end
            if (handoff) begin
                idx <= '0;
            end else if (state == SER_STREAM && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Data arrays need no reset: nothing reaches the outputs until got is full again.
    always_ff @(posedge clk) begin
        cap <= cap_next;
        if (handoff) begin
            stream_buf <= cap_next;
        end
    end

    assign myinputValid = (state == SER_STREAM);
    assign myinput      = myinputValid ? stream_buf[idx] : '0;
    assign busy         = (state != SER_IDLE) || pending;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed scenarios then random lane traffic,
// compared cycle by cycle against a vector-level reference model.
module tb_layer_out_serializer;

    localparam int N = 10;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   neuron_out;
    logic [N-1:0]     neuron_outvalid;
    logic [W-1:0]     myinput;
    logic             myinputValid;
    logic             busy;
    logic             overflow;

    layer_out_serializer #(.numNeuron(N), .dataWidth(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .neuron_out     (neuron_out),
        .neuron_outvalid(neuron_outvalid),
        .myinput        (myinput),
        .myinputValid   (myinputValid),
        .busy           (busy),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: lanes collected so far, a held complete vector, and the
    // cycle window in which the current burst is on the wire.
    int           cyc     = 0;
    int           s_start = -1000;
    logic [W-1:0] m_cap [N];
    logic [N-1:0] m_got;
    bit           m_pend;
    bit           m_ovf;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] vmask, input logic [N*W-1:0] data, input logic r);
        bit free;
        if (r) begin
            s_start = -1000;
            m_got   = '0;
            m_pend  = 0;
            m_ovf   = 0;
            exp_q.delete();
            return;
        end
        free = !(cyc >= s_start && cyc < s_start + N);
        if (m_pend) begin
            if (|vmask) m_ovf = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vmask[i]) begin
                    m_got[i] = 1'b1;
                    m_cap[i] = data[i*W +: W];
                end
            end
        end
        if (m_pend || (&m_got)) begin
            if (free) begin
                s_start = cyc + 1;
                for (int i = 0; i < N; i++) exp_q.push_back(m_cap[i]);
                m_got  = '0;
                m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit           in_stream;
        bit           in_gap;
        logic [W-1:0] exp_d;
        in_stream = (cyc >= s_start) && (cyc < s_start + N);
        in_gap    = (cyc == s_start + N);
        exp_d     = '0;
        if (in_stream && exp_q.size() > 0) exp_d = exp_q.pop_front();
        check("valid", 32'(myinputValid), 32'(in_stream));
        check("data", 32'(myinput), 32'(exp_d));
        check("busy", 32'(busy), 32'(in_stream || in_gap || m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic [N-1:0] vmask, input logic [N*W-1:0] data, input logic r);
        neuron_outvalid = vmask;
        neuron_out      = data;
        rst             = r;
        @(posedge clk);
        model_edge(vmask, data, r);
        cyc++;
        #1;
        check_outputs();
        neuron_outvalid = '0;
        rst             = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    task automatic lanes(input int lo, input int hi, input int base);
        logic [N-1:0]   m;
        logic [N*W-1:0] d;
        m = '0;
        d = '0;
        for (int i = lo; i <= hi; i++) begin
            m[i]       = 1'b1;
            d[i*W +: W] = W'(base + i);
        end
        step(m, d, 1'b0);
    endtask

    initial begin
        logic [N-1:0]   rm;
        logic [N*W-1:0] rd;
        rst             = 1'b1;
        neuron_out      = '0;
        neuron_outvalid = '0;
        for (int i = 0; i < N; i++) m_cap[i] = '0;
        m_got = '0;

        // Reset state
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        idle(2);

        // All lanes in one cycle, data 1..10
        lanes(0, N - 1, 1);
        idle(14);

        // Staggered lanes with a repeat on lane 2
        lanes(0, 4, 16'h10);
        idle(2);
        begin
            logic [N*W-1:0] d;
            d = '0;
            d[2*W +: W] = 16'hBEEF;
            step(10'b00_0000_0100, d, 1'b0);
        end
        idle(1);
        lanes(5, N - 1, 16'h10);
        idle(14);

        // Back-to-back: second vector arrives while the first streams
        lanes(0, N - 1, 16'h100);
        idle(3);
        lanes(0, N - 1, 16'h200);
        idle(25);

        // Overflow: third vector pending, then a stray lane pulse
        lanes(0, N - 1, 16'h300);
        idle(2);
        lanes(0, N - 1, 16'h400);
        idle(1);
        lanes(3, 3, 16'h500);
        idle(25);

        // Reset at element 4, then a fresh vector
        step('0, '0, 1'b1);
        lanes(0, N - 1, 16'h600);
        idle(4);
        step('0, '0, 1'b1);
        idle(1);
        lanes(0, N - 1, 16'h700);
        idle(14);

        // Random lane traffic with occasional full vectors and rare resets
        for (int c = 0; c < 600; c++) begin
            rm = '0;
            rd = '0;
            for (int i = 0; i < N; i++) begin
                rm[i]        = ($urandom_range(0, 3) == 0);
                rd[i*W +: W] = W'($urandom);
            end
            if ($urandom_range(0, 7) == 0) rm = '1;
            if ($urandom_range(0, 5) == 0) rm = '0;
            step(rm, rd, ($urandom_range(0, 199) == 0));
        end
        idle(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
